// File: rtl/fdivsqrt_otfc_seq.sv
// Sequential on-the-fly converter: signed digits (radix 2 or 4, DPC per cycle) into U and UM = U - ulp.
// Build option FDIVSQRT_OTFC_SELM_EN registers q = rem_neg ? UM : U when the conversion finishes.
//
// state | meaning
// IDLE  | after reset, nothing loaded
// BUSY  | accepting digit cycles until count reaches its terminal value
// DONE  | result held until the next start
module fdivsqrt_otfc_seq #(
    parameter int DIVb  = 64,
    parameter int RADIX = 2,
    parameter int DPC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sqrt_mode,
    input  logic [7:0]       iter,
    input  logic             digit_valid,
    input  logic [3*DPC-1:0] digits,
    input  logic             rem_neg,
    output logic             busy,
    output logic             done,
    output logic [DIVb:0]    u,
    output logic [DIVb:0]    um,
    output logic [DIVb:0]    q
);
    localparam int LR = (RADIX == 4) ? 2 : 1;
    localparam int PW = $clog2(DIVb + 1) + 2;
    localparam logic signed [PW-1:0] P_INIT = PW'(DIVb - LR);
    localparam logic signed [PW-1:0] P_STEP = PW'(LR);
    localparam logic [DIVb:0] ONE = {{DIVb{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [7:0]           count;
    logic signed [PW-1:0] p, p_nxt;
    logic [DIVb:0]        u_nxt, um_nxt, k1, k2, k3;
    logic [1:0]           mag;
    logic                 sgn;
    logic                 accept, finish;

    // start always wins over a coincident digit cycle
    assign accept = (state == BUSY) && digit_valid && !start;
    assign finish = accept && (count == 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start)       state_nxt = BUSY;
        else if (finish) state_nxt = DONE;
    end

    always_comb begin
        busy = (state == BUSY);
        done = (state == DONE);
    end

    // digits resolve in order; once the pointer goes negative nothing changes and it stops moving
    always_comb begin
        u_nxt  = u;
        um_nxt = um;
        p_nxt  = p;
        k1     = '0;
        k2     = '0;
        k3     = '0;
        mag    = '0;
        sgn    = 1'b0;
        for (int i = 0; i < DPC; i++) begin
            sgn = digits[3*i+2];
            mag = (RADIX == 4) ? digits[3*i +: 2] : {1'b0, digits[3*i]};
            if (!p_nxt[PW-1]) begin
                k1 = ONE << p_nxt[PW-2:0];
                k2 = k1 << 1;
                k3 = k1 | k2;
                if (mag == 2'd0) begin
                    um_nxt = um_nxt | ((RADIX == 4) ? k3 : k1);
                end else if (!sgn && mag == 2'd1) begin
                    um_nxt = u_nxt;
                    u_nxt  = u_nxt | k1;
                end else if (!sgn) begin
                    um_nxt = u_nxt | k1;
                    u_nxt  = u_nxt | k2;
                end else if (mag == 2'd1) begin
                    if (RADIX == 4) begin
                        u_nxt  = um_nxt | k3;
                        um_nxt = um_nxt | k2;
                    end else begin
                        u_nxt  = um_nxt | k1;
                    end
                end else begin
                    u_nxt  = um_nxt | k2;
                    um_nxt = um_nxt | k1;
                end
                p_nxt = p_nxt - P_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u     <= '0;
            um    <= '0;
            p     <= '0;
            count <= '0;
        end else if (start) begin
            u     <= sqrt_mode ? (ONE << DIVb) : '0;
            um    <= '0;
            p     <= P_INIT;
            count <= (iter == 8'd0) ? 8'd1 : iter;
        end else if (accept) begin
            u     <= u_nxt;
            um    <= um_nxt;
            p     <= p_nxt;
            count <= count - 8'd1;
        end
    end

`ifdef FDIVSQRT_OTFC_SELM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       q <= '0;
        else if (finish) q <= rem_neg ? um_nxt : u_nxt;
    end
`else
    logic unused_rem_neg;
    assign unused_rem_neg = rem_neg;
    assign q = u;
`endif

endmodule

// File: tb/tb_fdivsqrt_otfc_seq.sv
// Bench for fdivsqrt_otfc_seq: three DIVb=8 instances (r2/dpc1, r4/dpc1, r2/dpc2) share control inputs
// and are checked each cycle against an arithmetic model (U = sum d*w, UM = U - last weight).
module tb_fdivsqrt_otfc_seq;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          sqrt_mode = 1'b0;
    logic          digit_valid = 1'b0;
    logic          rem_neg = 1'b0;
    logic [7:0]    iter = '0;
    logic [2:0]    dg0 = '0;
    logic [2:0]    dg1 = '0;
    logic [5:0]    dg2 = '0;
    logic [DB:0]   u_o[3];
    logic [DB:0]   um_o[3];
    logic [DB:0]   q_o[3];
    logic          busy_o[3];
    logic          done_o[3];

    int RAD[3]  = '{2, 4, 2};
    int DPCS[3] = '{1, 1, 2};
    int dq[3][$];
    int dir_q[3][$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fdivsqrt_otfc_seq #(.DIVb(DB), .RADIX(2), .DPC(1)) dut_r2 (
        .clk(clk), .reset(reset), .start(start), .sqrt_mode(sqrt_mode), .iter(iter),
        .digit_valid(digit_valid), .digits(dg0), .rem_neg(rem_neg),
        .busy(busy_o[0]), .done(done_o[0]), .u(u_o[0]), .um(um_o[0]), .q(q_o[0]));
    fdivsqrt_otfc_seq #(.DIVb(DB), .RADIX(4), .DPC(1)) dut_r4 (
        .clk(clk), .reset(reset), .start(start), .sqrt_mode(sqrt_mode), .iter(iter),
        .digit_valid(digit_valid), .digits(dg1), .rem_neg(rem_neg),
        .busy(busy_o[1]), .done(done_o[1]), .u(u_o[1]), .um(um_o[1]), .q(q_o[1]));
    fdivsqrt_otfc_seq #(.DIVb(DB), .RADIX(2), .DPC(2)) dut_r2x2 (
        .clk(clk), .reset(reset), .start(start), .sqrt_mode(sqrt_mode), .iter(iter),
        .digit_valid(digit_valid), .digits(dg2), .rem_neg(rem_neg),
        .busy(busy_o[2]), .done(done_o[2]), .u(u_o[2]), .um(um_o[2]), .q(q_o[2]));

    // Arithmetic view: each digit adds d*weight; UM is U minus the weight of the last resolved digit.
    function automatic void ref_model(input int radix, input bit sq, input int ds[$],
                                      output int eu, output int eum);
        int lr = (radix == 4) ? 2 : 1;
        int p = DB - lr;
        eu  = sq ? (1 << DB) : 0;
        eum = 0;
        foreach (ds[i]) begin
            if (p >= 0) begin
                eu  = eu + ds[i] * (1 << p);
                eum = eu - (1 << p);
                p   = p - lr;
            end
        end
    endfunction

    function automatic logic [2:0] enc(input int d, input int radix);
        logic [2:0] e;
        int nd;
        nd = -d;
        if (d > 0)      e = {1'b0, d[1:0]};
        else if (d < 0) e = {1'b1, nd[1:0]};
        else            e = {1'($urandom_range(0, 1)), 2'b00};
        if (radix == 2 && d != 0) e[1] = 1'($urandom_range(0, 1));
        return e;
    endfunction

    function automatic int rand_digit(input int radix, input bit first_div);
        if (first_div) return (radix == 4) ? int'($urandom_range(1, 2)) : 1;
        return (radix == 4) ? int'($urandom_range(0, 4)) - 2 : int'($urandom_range(0, 2)) - 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit sq, input int it, input bit gaps, input int stop_after, input int hold);
        int n, acc, cyc, eu, eum, d;
        logic [DB:0] init;
        logic [DB:0] eq[3];
        logic rn_fin;
        logic [2:0] e;
        n = (it == 0) ? 1 : it;
        acc = 0;
        cyc = 0;
        rn_fin = 1'b0;
        for (int k = 0; k < 3; k++) dq[k].delete();
        start = 1'b1;
        sqrt_mode = sq;
        iter = it[7:0];
        digit_valid = 1'b1;
        dg0 = 3'($urandom);
        dg1 = 3'($urandom);
        dg2 = 6'($urandom);
        step();
        start = 1'b0;
        iter = 8'($urandom);
        init = sq ? 9'h100 : 9'h000;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy_o[k] !== 1'b1 || done_o[k] !== 1'b0 || u_o[k] !== init || um_o[k] !== 9'h000)
                $display("FAIL load dut%0d: busy=%b done=%b u=%h um=%h, want busy=1 done=0 u=%h um=000",
                         k, busy_o[k], done_o[k], u_o[k], um_o[k], init);
            else n_pass++;
        end
        while (acc < n && cyc < 8 * n + 40) begin
            if (stop_after >= 0 && acc == stop_after) return;
            digit_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            rem_neg = 1'($urandom);
            dg0 = 3'($urandom);
            dg1 = 3'($urandom);
            dg2 = 6'($urandom);
            if (digit_valid) begin
                for (int k = 0; k < 3; k++) begin
                    for (int j = 0; j < DPCS[k]; j++) begin
                        if (dir_q[k].size() > 0) d = dir_q[k].pop_front();
                        else d = rand_digit(RAD[k], !sq && dq[k].size() == 0);
                        dq[k].push_back(d);
                        e = enc(d, RAD[k]);
                        if (k == 0) dg0 = e;
                        else if (k == 1) dg1 = e;
                        else dg2[3*j +: 3] = e;
                    end
                end
                if (acc + 1 == n) rn_fin = rem_neg;
            end
            step();
            cyc++;
            if (digit_valid) acc++;
            for (int k = 0; k < 3; k++) begin
                ref_model(RAD[k], sq, dq[k], eu, eum);
                n_checks++;
                if (u_o[k] !== 9'(eu) || um_o[k] !== 9'(eum) ||
                    busy_o[k] !== (acc < n) || done_o[k] !== (acc == n))
                    $display("FAIL step dut%0d acc=%0d: u=%h um=%h busy=%b done=%b, want u=%h um=%h busy=%b done=%b",
                             k, acc, u_o[k], um_o[k], busy_o[k], done_o[k], 9'(eu), 9'(eum), acc < n, acc == n);
                else n_pass++;
            end
        end
        digit_valid = 1'b0;
        n_checks++;
        if (acc != n) $display("FAIL timeout: accepted %0d digit cycles, want %0d", acc, n);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            ref_model(RAD[k], sq, dq[k], eu, eum);
`ifdef FDIVSQRT_OTFC_SELM_EN
            eq[k] = rn_fin ? 9'(eum) : 9'(eu);
`else
            eq[k] = 9'(eu);
`endif
            n_checks++;
            if (q_o[k] !== eq[k]) $display("FAIL q dut%0d: got %h, want %h", k, q_o[k], eq[k]);
            else n_pass++;
        end
        for (int h = 0; h < hold; h++) begin
            digit_valid = 1'b1;
            rem_neg = ~rem_neg;
            dg0 = 3'b001;
            dg1 = 3'b010;
            dg2 = 6'b001001;
            step();
            for (int k = 0; k < 3; k++) begin
                ref_model(RAD[k], sq, dq[k], eu, eum);
                n_checks++;
                if (u_o[k] !== 9'(eu) || um_o[k] !== 9'(eum) || q_o[k] !== eq[k] ||
                    done_o[k] !== 1'b1 || busy_o[k] !== 1'b0)
                    $display("FAIL hold dut%0d: u=%h um=%h q=%h done=%b busy=%b, want u=%h um=%h q=%h done=1 busy=0",
                             k, u_o[k], um_o[k], q_o[k], done_o[k], busy_o[k], 9'(eu), 9'(eum), eq[k]);
                else n_pass++;
            end
        end
        digit_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        reset = 1'b0;
        digit_valid = 1'b1;
        dg0 = 3'b001;
        dg1 = 3'b010;
        dg2 = 6'b001001;
        step();
        digit_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || u_o[k] !== '0 || um_o[k] !== '0 || q_o[k] !== '0)
                $display("FAIL reset dut%0d: busy=%b done=%b u=%h um=%h q=%h, want all 0",
                         k, busy_o[k], done_o[k], u_o[k], um_o[k], q_o[k]);
            else n_pass++;
        end
    endtask

    task automatic test_plan_vectors();
        dir_q[0] = '{1, 0, -1, 1};
        run_op(1'b0, 4, 1'b0, -1, 1);
        n_checks++;
        if (u_o[0] !== 9'h070 || um_o[0] !== 9'h060)
            $display("FAIL plan_r2: u=%h um=%h, want 070 060", u_o[0], um_o[0]);
        else n_pass++;
        dir_q[1] = '{2, -1};
        run_op(1'b0, 2, 1'b0, -1, 0);
        n_checks++;
        if (u_o[1] !== 9'h070 || um_o[1] !== 9'h060)
            $display("FAIL plan_r4: u=%h um=%h, want 070 060", u_o[1], um_o[1]);
        else n_pass++;
        dir_q[2] = '{-1, 1};
        run_op(1'b1, 1, 1'b0, -1, 0);
        n_checks++;
        if (u_o[2] !== 9'h0C0 || um_o[2] !== 9'h080)
            $display("FAIL plan_sqrt_dpc2: u=%h um=%h, want 0c0 080", u_o[2], um_o[2]);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            dir_q[0].push_back(1);
            dir_q[1].push_back(1);
        end
        for (int i = 0; i < 24; i++) dir_q[2].push_back(1);
        run_op(1'b0, 12, 1'b0, -1, 2);
        n_checks++;
        if (u_o[0] !== 9'h0FF || um_o[0] !== 9'h0FE)
            $display("FAIL plan_overrun: u=%h um=%h, want 0ff 0fe", u_o[0], um_o[0]);
        else n_pass++;
    endtask

    task automatic test_iter_zero();
        run_op(1'b0, 0, 1'b0, -1, 1);
    endtask

    task automatic test_abort();
        run_op(1'b0, 6, 1'b0, 3, 0);
        run_op(1'b1, 5, 1'b1, -1, 1);
    endtask

    task automatic test_reset_mid();
        run_op(1'b1, 8, 1'b0, 3, 0);
        digit_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || u_o[k] !== '0 || um_o[k] !== '0 || q_o[k] !== '0)
                $display("FAIL reset_mid dut%0d: busy=%b done=%b u=%h um=%h q=%h, want all 0",
                         k, busy_o[k], done_o[k], u_o[k], um_o[k], q_o[k]);
            else n_pass++;
        end
        step();
        reset = 1'b0;
        digit_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) run_op(1'($urandom), int'($urandom_range(1, 6)), 1'b0, -1, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++)
            run_op(1'($urandom), int'($urandom_range(0, 14)), 1'b1, -1, int'($urandom_range(0, 2)));
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_iter_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
